// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline encodings: FSM states, PC-source selects and stage control bundles.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      PCSRC_SEQ = 2'd0,
      PCSRC_BR  = 2'd1,
      PCSRC_JMP = 2'd2
   } pc_src_e;

   // Per-cycle control bundle driven into the PC and pipeline registers
   typedef struct packed {
      logic    pc_write;
      logic    ifid_write;
      logic    ifid_flush;
      logic    idex_bubble;
      logic    exmem_flush;
      logic    exmem_hold;
      pc_src_e pc_src;
   } ctrl_t;

   // All enables and clears low: the NOP / zero-control pattern
   localparam ctrl_t CTRL_NOP = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                  idex_bubble: 1'b0, exmem_flush: 1'b0, exmem_hold: 1'b0,
                                  pc_src: PCSRC_SEQ};

   // Free-running pipeline
   localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                  idex_bubble: 1'b0, exmem_flush: 1'b0, exmem_hold: 1'b0,
                                  pc_src: PCSRC_SEQ};

   // Held in reset: front end frozen, every in-flight slot cleared
   localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                    idex_bubble: 1'b1, exmem_flush: 1'b1, exmem_hold: 1'b0,
                                    pc_src: PCSRC_SEQ};

   // Whole pipeline frozen behind the MEM stage
   localparam ctrl_t CTRL_HOLD = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                   idex_bubble: 1'b0, exmem_flush: 1'b0, exmem_hold: 1'b1,
                                   pc_src: PCSRC_SEQ};

   // Load in ID/EX feeds a source of the instruction in IF/ID; r0 never counts
   function automatic logic is_loaduse(input logic             memread,
                                       input logic [REG_W-1:0] ld_rt,
                                       input logic [REG_W-1:0] use_rs,
                                       input logic [REG_W-1:0] use_rt);
      return memread && (ld_rt != REG_W'(0)) && ((ld_rt == use_rs) || (ld_rt == use_rt));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   // Count enabled cycles, sticking at all-ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MEM redirects, dmem waits.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             exmem_branch,
   input  logic             exmem_zero,
   input  logic             exmem_jump,
   input  logic             exmem_memr,
   input  logic             exmem_memw,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_flush,
   output logic             exmem_hold,
   output logic [1:0]       pc_src,
   output logic [1:0]       state_o,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
   ctrl_t             ctrl;
   logic              flush_inc;
   logic              memwait, redirect, loaduse;

   // Hazard event decode from the current pipeline-register outputs
   always_comb begin
      memwait  = (exmem_memr | exmem_memw) & ~dmem_ready;
      redirect = (exmem_branch & exmem_zero) | exmem_jump;
      loaduse  = is_loaduse(idex_memread, idex_rt, ifid_rs, ifid_rt);
   end

   // Next-state and stage controls; reset overrides the controls combinationally
   always_comb begin
      ctrl      = CTRL_RUN;
      state_d   = state_q;
      wait_d    = wait_q;
      err_d     = err_q;
      flush_inc = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (memwait) begin
               ctrl    = CTRL_HOLD;
               state_d = ST_MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end else if (redirect) begin
               ctrl.ifid_flush  = 1'b1;
               ctrl.idex_bubble = 1'b1;
               ctrl.exmem_flush = 1'b1;
               ctrl.pc_src      = exmem_jump ? PCSRC_JMP : PCSRC_BR;
               flush_inc        = 1'b1;
            end else if (loaduse) begin
               ctrl.pc_write    = 1'b0;
               ctrl.ifid_write  = 1'b0;
               ctrl.idex_bubble = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ready) begin
               // EX/MEM holds a memory op, so only loaduse can apply here
               state_d = ST_RUN;
               wait_d  = '0;
               if (loaduse) begin
                  ctrl.pc_write    = 1'b0;
                  ctrl.ifid_write  = 1'b0;
                  ctrl.idex_bubble = 1'b1;
               end
            end else begin
               ctrl = CTRL_HOLD;
               if (wait_q >= WAIT_W'(MEM_TIMEOUT)) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         end
         ST_ERR: begin
            ctrl = CTRL_HOLD;
         end
         default: begin
            ctrl    = CTRL_NOP;
            state_d = ST_RUN;
         end
      endcase
      if (!rst_n) begin
         ctrl      = CTRL_RESET;
         flush_inc = 1'b0;
      end
   end

   // State, wait counter and sticky error flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~ctrl.pc_write),
      .cnt   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .cnt   (flush_cnt)
   );

   assign pc_write    = ctrl.pc_write;
   assign ifid_write  = ctrl.ifid_write;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_bubble = ctrl.idex_bubble;
   assign exmem_flush = ctrl.exmem_flush;
   assign exmem_hold  = ctrl.exmem_hold;
   assign pc_src      = ctrl.pc_src;
   assign state_o     = state_q;
   assign mem_err     = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a rule-level reference model checked every cycle.
module tb_pipe_hazard_ctrl;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned TIMEOUT = 4;
   localparam int          CMAX    = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       idex_memread;
   logic [4:0] idex_rt, ifid_rs, ifid_rt;
   logic       exmem_branch, exmem_zero, exmem_jump, exmem_memr, exmem_memw, dmem_ready;
   logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, exmem_hold;
   logic [1:0] pc_src, state_o;
   logic       mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .exmem_branch(exmem_branch), .exmem_zero(exmem_zero), .exmem_jump(exmem_jump),
      .exmem_memr(exmem_memr), .exmem_memw(exmem_memw), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .exmem_hold(exmem_hold),
      .pc_src(pc_src), .state_o(state_o), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Reference model: mode 0 run, 1 waiting on memory, 2 error
   int m_mode = 0, m_mwcyc = 0, m_err = 0, m_stall = 0, m_flush = 0;
   bit ev_mw, ev_rd, ev_lu, took_redirect;
   int e_pcw, e_ifw, e_iff, e_bub, e_exf, e_hold, e_src;

   always @(negedge clk) begin
      ev_mw = (exmem_memr || exmem_memw) && !dmem_ready;
      ev_rd = (exmem_branch && exmem_zero) || exmem_jump;
      ev_lu = idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
      e_pcw = 1; e_ifw = 1; e_iff = 0; e_bub = 0; e_exf = 0; e_hold = 0; e_src = 0;
      took_redirect = 1'b0;
      if (!rst_n) begin
         e_pcw = 0; e_ifw = 0; e_iff = 1; e_bub = 1; e_exf = 1;
      end else if (m_mode == 2 || (m_mode == 1 && !dmem_ready) || (m_mode == 0 && ev_mw)) begin
         e_pcw = 0; e_ifw = 0; e_hold = 1;
      end else if (m_mode == 0 && ev_rd) begin
         e_iff = 1; e_bub = 1; e_exf = 1; e_src = exmem_jump ? 2 : 1;
         took_redirect = 1'b1;
      end else if (ev_lu) begin
         e_pcw = 0; e_ifw = 0; e_bub = 1;
      end
      if (chk_en) begin
         cmp("pc_write", int'(pc_write), e_pcw);
         cmp("ifid_write", int'(ifid_write), e_ifw);
         cmp("ifid_flush", int'(ifid_flush), e_iff);
         cmp("idex_bubble", int'(idex_bubble), e_bub);
         cmp("exmem_flush", int'(exmem_flush), e_exf);
         cmp("exmem_hold", int'(exmem_hold), e_hold);
         cmp("pc_src", int'(pc_src), e_src);
         cmp("state_o", int'(state_o), m_mode);
         cmp("mem_err", int'(mem_err), m_err);
         cmp("stall_cnt", int'(stall_cnt), m_stall);
         cmp("flush_cnt", int'(flush_cnt), m_flush);
      end
      // Advance the model to what the coming rising edge produces
      if (!rst_n) begin
         m_mode = 0; m_mwcyc = 0; m_err = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (e_pcw == 0 && m_stall < CMAX) m_stall++;
         if (took_redirect && m_flush < CMAX) m_flush++;
         if (m_mode == 0 && ev_mw) begin
            m_mode = 1; m_mwcyc = 0;
         end else if (m_mode == 1) begin
            if (dmem_ready) m_mode = 0;
            else begin
               m_mwcyc++;
               if (m_mwcyc == TIMEOUT) begin
                  m_mode = 2; m_err = 1;
               end
            end
         end
      end
   end

   task automatic idle();
      idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
      exmem_branch = 0; exmem_zero = 0; exmem_jump = 0;
      exmem_memr = 0; exmem_memw = 0; dmem_ready = 0;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      idle();
      adv();
      chk_en = 1'b1;
      @(negedge clk);
      cmp("lit_rst_pc_write", int'(pc_write), 0);
      cmp("lit_rst_idex_bubble", int'(idex_bubble), 1);
      cmp("lit_rst_state", int'(state_o), 0);
      cmp("lit_rst_stall", int'(stall_cnt), 0);
      adv();
      rst_n = 1;

      // Load-use on rs, then the same with r0
      idex_memread = 1; idex_rt = 8; ifid_rs = 8;
      @(negedge clk);
      cmp("lit_lu_pc_write", int'(pc_write), 0);
      cmp("lit_lu_bubble", int'(idex_bubble), 1);
      adv();
      idex_rt = 0; ifid_rs = 0;
      @(negedge clk);
      cmp("lit_lu_r0_pc_write", int'(pc_write), 1);
      cmp("lit_lu_stall", int'(stall_cnt), 1);
      adv();

      // Taken branch, then not-taken
      idle(); exmem_branch = 1; exmem_zero = 1;
      @(negedge clk);
      cmp("lit_br_pc_src", int'(pc_src), 1);
      cmp("lit_br_exmem_flush", int'(exmem_flush), 1);
      adv();
      exmem_zero = 0;
      @(negedge clk);
      cmp("lit_br_nt_pc_src", int'(pc_src), 0);
      cmp("lit_br_flush_cnt", int'(flush_cnt), 1);
      adv();

      // Jump plus a load-use condition: redirect wins
      idle(); exmem_jump = 1; idex_memread = 1; idex_rt = 5; ifid_rt = 5;
      @(negedge clk);
      cmp("lit_jmp_pc_src", int'(pc_src), 2);
      cmp("lit_jmp_pc_write", int'(pc_write), 1);
      adv();
      idle();
      @(negedge clk);
      cmp("lit_jmp_flush_cnt", int'(flush_cnt), 2);
      adv();

      // Fresh start, then a 3-cycle memory wait
      rst_n = 0; adv(); rst_n = 1;
      exmem_memr = 1; dmem_ready = 0;
      adv(); adv(); adv();
      dmem_ready = 1;
      @(negedge clk);
      cmp("lit_mw_state", int'(state_o), 1);
      cmp("lit_mw_stall", int'(stall_cnt), 3);
      cmp("lit_mw_pc_write", int'(pc_write), 1);
      adv();
      idle();
      @(negedge clk);
      cmp("lit_mw_back_run", int'(state_o), 0);
      adv();

      // Timeout into ERR: one RUN cycle plus four MEM_WAIT cycles
      exmem_memr = 1; dmem_ready = 0;
      repeat (5) adv();
      @(negedge clk);
      cmp("lit_to_state", int'(state_o), 2);
      cmp("lit_to_mem_err", int'(mem_err), 1);
      cmp("lit_to_stall", int'(stall_cnt), 8);
      adv();
      idle(); dmem_ready = 1; exmem_jump = 1;
      @(negedge clk);
      cmp("lit_err_frozen_pc_write", int'(pc_write), 0);
      cmp("lit_err_frozen_hold", int'(exmem_hold), 1);
      adv();
      rst_n = 0;
      adv();
      rst_n = 1; idle();
      @(negedge clk);
      cmp("lit_rst_from_err_state", int'(state_o), 0);
      cmp("lit_rst_from_err_mem_err", int'(mem_err), 0);
      cmp("lit_rst_from_err_stall", int'(stall_cnt), 0);
      adv();

      // Saturation: 20 load-use stall cycles on a 4-bit counter
      idex_memread = 1; idex_rt = 3; ifid_rt = 3;
      repeat (20) adv();
      idle();
      @(negedge clk);
      cmp("lit_sat_stall", int'(stall_cnt), 15);
      adv();
      adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Watches the ID/EX and EX/MEM pipeline-register outputs and the data-memory ready line.
- Drives the write-enable, flush and bubble controls of PC, IF/ID, ID/EX and EX/MEM, plus the PC-source select.
- Resolves load-use hazards, taken-branch/jump redirects from MEM, and variable-latency data-memory waits with a timeout.

Parameters:
- CNT_W, 16: width of the stall and flush performance counters.
- MEM_TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before entering ERR.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- idex_memread  in  1  MemRead of the instruction in ID/EX
- idex_rt  in  5  destination rt of the instruction in ID/EX
- ifid_rs  in  5  rs field of the instruction in IF/ID
- ifid_rt  in  5  rt field of the instruction in IF/ID
- exmem_branch  in  1  Branch flag from EX/MEM
- exmem_zero  in  1  ALU zero flag from EX/MEM
- exmem_jump  in  1  jump flag from EX/MEM
- exmem_memr  in  1  MemRead from EX/MEM
- exmem_memw  in  1  MemWrite from EX/MEM
- dmem_ready  in  1  data memory access complete this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_bubble  out  1  ID/EX control fields forced to 0
- exmem_flush  out  1  EX/MEM control fields forced to 0
- exmem_hold  out  1  EX/MEM and MEM/WB hold current contents
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR
- mem_err  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  cycles with pc_write = 0, saturating
- flush_cnt  out  CNT_W  redirects taken, saturating

Behaviour:
- Reset (rst_n = 0 at a clk edge): state = RUN, counters = 0, wait counter = 0, mem_err = 0.
- While rst_n = 0, outputs are pc_write = 0, ifid_write = 0, ifid_flush = 1, idex_bubble = 1, exmem_flush = 1, exmem_hold = 0, pc_src = 0.
- Reset applied mid-MEM_WAIT or in ERR returns to RUN on that edge.
- Control outputs are combinational from the state and the current inputs. State, counters and mem_err are registered.
- Default (RUN, no event): pc_write = 1, ifid_write = 1, all flush/bubble/hold = 0, pc_src = 0.
- Event decode in RUN:
  - memwait = (exmem_memr | exmem_memw) & ~dmem_ready
  - redirect = (exmem_branch & exmem_zero) | exmem_jump
  - loaduse = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt)
- Priority in RUN: memwait > redirect > loaduse. Only the winning event drives outputs.
- memwait:
  - pc_write = 0, ifid_write = 0, exmem_hold = 1, idex_bubble = 0.
  - Next state MEM_WAIT, wait counter = 1.
- redirect:
  - pc_write = 1, pc_src = exmem_jump ? 2 : 1; jump wins if both redirect terms are set.
  - ifid_flush = 1, idex_bubble = 1, exmem_flush = 1.
  - flush_cnt increments. Latency 0: the target is loaded at this edge.
  - State stays RUN.
- loaduse:
  - pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - Exactly one bubble cycle per hazard, since the load advances on the next edge. State stays RUN.
- MEM_WAIT, while dmem_ready = 0:
  - Same outputs as memwait; the wait counter increments.
  - When the wait counter reaches MEM_TIMEOUT with dmem_ready still 0: next state ERR, mem_err = 1.
- MEM_WAIT, when dmem_ready = 1:
  - Outputs revert to default RUN outputs, with loaduse evaluated normally this cycle.
  - Redirect is not possible, because the EX/MEM entry is a memory operation.
  - Next state RUN.
- ERR:
  - pc_write = 0, ifid_write = 0, exmem_hold = 1.
  - Remains in ERR until reset; mem_err stays 1.
- stall_cnt increments on every cycle with pc_write = 0 and rst_n = 1. Both counters saturate at all-ones with no wrap.
- Register 0 is never a hazard source; idex_rt = 0 suppresses loaduse.

Decomposition:
- Shared pipeline package holds:
  - FSM state encodings ST_RUN / ST_MEM_WAIT / ST_ERR
  - pc_src encodings PCSRC_SEQ / PCSRC_BR / PCSRC_JMP
  - the NOP/zero-control constant used by flush
- One sub-module: sat_counter (CNT_W wide, inc enable, synchronous active-low clear). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Load-use: idex_memread = 1, idex_rt = 8, ifid_rs = 8 for one cycle.
  - That cycle: pc_write = 0, ifid_write = 0, idex_bubble = 1; stall_cnt 0 -> 1.
  - Repeat with idex_rt = 0: no stall.
- Taken branch: exmem_branch = 1, exmem_zero = 1 -> pc_src = 1, ifid_flush = idex_bubble = exmem_flush = 1, flush_cnt = 1.
  - Same with exmem_zero = 0 -> default outputs.
- Jump with a simultaneous loaduse condition -> pc_src = 2, flushes asserted, pc_write = 1; redirect wins over loaduse.
- Memory wait: exmem_memr = 1, dmem_ready = 0 for 3 cycles, then 1.
  - state_o = 1 for 3 cycles, exmem_hold = 1, stall_cnt = 3.
  - On the ready cycle: state returns to 0, pc_write = 1.
- Timeout: MEM_TIMEOUT = 4, dmem_ready held at 0.
  - ERR entered after 4 wait cycles, mem_err = 1, outputs frozen.
  - rst_n = 0 for one edge -> RUN, mem_err = 0, counters = 0.
- Saturation: CNT_W = 4, hold loaduse for 20 cycles -> stall_cnt stops at 15.
